// File: rtl/tq_pkg.sv
// tq_pkg: shared encodings and tables for the HEVC quantiser-parameter path.
// Rev 1.0
`default_nettype none

package tq_pkg;

    localparam logic [1:0] DCT_4  = 2'd0;
    localparam logic [1:0] DCT_8  = 2'd1;
    localparam logic [1:0] DCT_16 = 2'd2;
    localparam logic [1:0] DCT_32 = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLIP = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [7:0] OFF_BASE_INTRA = 8'd171;
    localparam logic [7:0] OFF_BASE_INTER = 8'd85;

    localparam logic [5:0] QP_MAX = 6'd51;

    localparam logic [14:0] FWD_SCALE [6] = '{15'd26214, 15'd23302, 15'd20560,
                                              15'd18396, 15'd16384, 15'd14564};
    localparam logic [6:0]  INV_SCALE [6] = '{7'd40, 7'd45, 7'd51, 7'd57, 7'd64, 7'd72};

    // Chroma QP for qPi = 30..43 in 4:2:0.
    localparam logic [5:0] CHROMA_MAP [14] = '{6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd33, 6'd34,
                                               6'd34, 6'd35, 6'd35, 6'd36, 6'd36, 6'd37, 6'd37};

    typedef struct packed {
        logic [5:0]        qp;
        logic              chroma;
        logic signed [4:0] cqp;
        logic              inter;
        logic              inverse;
        logic [1:0]        transize;
    } qp_job_t;

    function automatic logic [2:0] log2_size(input logic [1:0] transize);
        logic [2:0] l;
        case (transize)
            DCT_4:   l = 3'd2;
            DCT_8:   l = 3'd3;
            DCT_16:  l = 3'd4;
            DCT_32:  l = 3'd5;
            default: l = 3'd2;
        endcase
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qp_chroma_map.sv
// qp_chroma_map: combinational 4:2:0 mapping of clipped chroma qPi to QpC.
// Rev 1.0
`default_nettype none

module qp_chroma_map
    import tq_pkg::*;
(
    input  logic signed [7:0] qpi,
    output logic signed [7:0] qpc
);

    logic signed [7:0] rel;
    logic [3:0]        idx;

    assign rel = qpi - 8'sd30;
    assign idx = rel[3:0];

    always_comb begin
        if (qpi < 8'sd30) begin
            qpc = qpi;
        end else if (qpi <= 8'sd43) begin
            qpc = $signed({2'b00, CHROMA_MAP[idx]});
        end else begin
            qpc = qpi - 8'sd6;
        end
    end

endmodule

`default_nettype wire

// File: rtl/quant_param_seq.sv
// quant_param_seq: sequential generator of HEVC quant/dequant Q, offset and shift.
// Rev 1.0
`default_nettype none

module quant_param_seq
    import tq_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int Q_W       = 20,
    parameter int OFF_W     = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [5:0]              i_qp,
    input  logic                    i_chroma,
    input  logic signed [4:0]       i_cqp_offset,
    input  logic                    i_type,
    input  logic                    i_inverse,
    input  logic [1:0]              i_transize,
    output logic                    o_valid,
    output logic signed [Q_W-1:0]   Q,
    output logic signed [OFF_W-1:0] offset,
    output logic [4:0]              shift
);

    localparam int              QP_BD_OFFSET = 6 * (BIT_DEPTH - 8);
    localparam int              QPI_MIN_I    = -QP_BD_OFFSET;
    localparam logic signed [7:0] QPI_MIN    = 8'(QPI_MIN_I);
    localparam logic signed [7:0] QPI_MAX    = 8'sd57;
    localparam logic signed [7:0] BD_OFF     = 8'(QP_BD_OFFSET);

    logic [1:0]        state;
    qp_job_t           job;
    logic [7:0]        r;
    logic [3:0]        per;

    logic [5:0]        qp_in_sat;
    logic signed [4:0] cqp_in_clip;
    logic signed [7:0] qp_sum;
    logic signed [7:0] qpi;
    logic signed [7:0] qpc;
    logic signed [7:0] qp_prime;

    logic [2:0]        log2n;
    logic [5:0]        fwd_shift;
    logic [5:0]        inv_shift;
    logic [Q_W-1:0]    q_fwd;
    logic [Q_W-1:0]    q_inv;
    logic [OFF_W-1:0]  off_fwd;
    logic [OFF_W-1:0]  off_inv;

    assign o_ready = (state == ST_IDLE);

    // Saturation of the raw request happens on the way into the job register.
    assign qp_in_sat   = (i_qp > QP_MAX) ? QP_MAX : i_qp;
    assign cqp_in_clip = (i_cqp_offset < -5'sd12) ? -5'sd12 :
                         (i_cqp_offset >  5'sd12) ?  5'sd12 : i_cqp_offset;

    assign qp_sum = $signed({2'b00, job.qp}) + $signed({{3{job.cqp[4]}}, job.cqp});

    always_comb begin
        if (qp_sum < QPI_MIN) begin
            qpi = QPI_MIN;
        end else if (qp_sum > QPI_MAX) begin
            qpi = QPI_MAX;
        end else begin
            qpi = qp_sum;
        end
    end

    qp_chroma_map u_chroma_map (
        .qpi (qpi),
        .qpc (qpc)
    );

    assign qp_prime = job.chroma ? (qpc + BD_OFF) : ($signed({2'b00, job.qp}) + BD_OFF);

    // shift = 14 + per + (15 - BIT_DEPTH - log2N); never negative for BIT_DEPTH <= 12.
    assign log2n     = log2_size(job.transize);
    assign fwd_shift = 6'(29 - BIT_DEPTH) + {2'b00, per} - {3'b000, log2n};
    assign inv_shift = 6'(BIT_DEPTH) + {3'b000, log2n} - 6'd9;

    assign q_fwd   = Q_W'(FWD_SCALE[r[2:0]]);
    assign q_inv   = Q_W'(INV_SCALE[r[2:0]]) << per;
    assign off_fwd = OFF_W'(job.inter ? OFF_BASE_INTER : OFF_BASE_INTRA) << (fwd_shift - 6'd9);
    assign off_inv = OFF_W'(1) << (inv_shift - 6'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            job     <= '0;
            r       <= '0;
            per     <= '0;
            o_valid <= 1'b0;
            Q       <= '0;
            offset  <= '0;
            shift   <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        job.qp       <= qp_in_sat;
                        job.chroma   <= i_chroma;
                        job.cqp      <= cqp_in_clip;
                        job.inter    <= i_type;
                        job.inverse  <= i_inverse;
                        job.transize <= i_transize;
                        state        <= ST_CLIP;
                    end
                end
                ST_CLIP: begin
                    r     <= qp_prime;
                    per   <= '0;
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    // Iterative qp' / 6 and qp' % 6, one subtraction per cycle.
                    if (r >= 8'd6) begin
                        r   <= r - 8'd6;
                        per <= per + 4'd1;
                    end else begin
                        Q       <= job.inverse ? q_inv : q_fwd;
                        offset  <= job.inverse ? off_inv : off_fwd;
                        shift   <= job.inverse ? inv_shift[4:0] : fwd_shift[4:0];
                        o_valid <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quant_param_seq.sv
// tb_quant_param_seq: scoreboard bench for quant_param_seq at BIT_DEPTH 8 and 10.
// Rev 1.0
`default_nettype none

module tb_quant_param_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [5:0]        qp;
    logic              chroma;
    logic signed [4:0] cqo;
    logic              typ;
    logic              inv;
    logic [1:0]        ts;
    logic              v8, v10;

    logic              rdy8, ov8, rdy10, ov10;
    logic signed [19:0] q8, q10;
    logic signed [27:0] off8, off10;
    logic [4:0]         sh8, sh10;

    quant_param_seq #(.BIT_DEPTH(8), .Q_W(20), .OFF_W(28)) dut8 (
        .clk(clk), .rst(rst), .i_valid(v8), .o_ready(rdy8), .i_qp(qp), .i_chroma(chroma),
        .i_cqp_offset(cqo), .i_type(typ), .i_inverse(inv), .i_transize(ts),
        .o_valid(ov8), .Q(q8), .offset(off8), .shift(sh8)
    );

    quant_param_seq #(.BIT_DEPTH(10), .Q_W(20), .OFF_W(28)) dut10 (
        .clk(clk), .rst(rst), .i_valid(v10), .o_ready(rdy10), .i_qp(qp), .i_chroma(chroma),
        .i_cqp_offset(cqo), .i_type(typ), .i_inverse(inv), .i_transize(ts),
        .o_valid(ov10), .Q(q10), .offset(off10), .shift(sh10)
    );

    typedef struct {
        longint q;
        longint off;
        longint sh;
        int     cyc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb10[$];
    exp_t e8, e10;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst && ov8) begin
            if (sb8.size() == 0) begin
                check("dut8 spurious o_valid", longint'(ov8), 0);
            end else begin
                e8 = sb8.pop_front();
                check("dut8 Q", longint'(q8), e8.q);
                check("dut8 offset", longint'(off8), e8.off);
                check("dut8 shift", longint'(sh8), e8.sh);
                check("dut8 o_valid cycle", longint'(cyc), longint'(e8.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ov10) begin
            if (sb10.size() == 0) begin
                check("dut10 spurious o_valid", longint'(ov10), 0);
            end else begin
                e10 = sb10.pop_front();
                check("dut10 Q", longint'(q10), e10.q);
                check("dut10 offset", longint'(off10), e10.off);
                check("dut10 shift", longint'(sh10), e10.sh);
                check("dut10 o_valid cycle", longint'(cyc), longint'(e10.cyc));
            end
        end
    end

    // Called at a negedge. lat = edges from the accept edge to the o_valid edge (2 + per).
    task automatic send(input bit sel, input int qpv, input int chr, input int cq, input int ty,
                        input int iv, input int tsz, input longint eq, input longint eoff,
                        input longint esh, input int lat, input bit push);
        int   waited;
        exp_t e;
        waited  = 0;
        qp      = 6'(qpv);
        chroma  = 1'(chr);
        cqo     = 5'(cq);
        typ     = 1'(ty);
        inv     = 1'(iv);
        ts      = 2'(tsz);
        if (sel) v10 = 1'b1; else v8 = 1'b1;
        while (!(sel ? rdy10 : rdy8)) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                check("accept timeout", longint'(waited), 0);
                v8  = 1'b0;
                v10 = 1'b0;
                return;
            end
        end
        if (push) begin
            e.q   = eq;
            e.off = eoff;
            e.sh  = esh;
            e.cyc = cyc + 1 + lat;
            if (sel) sb10.push_back(e); else sb8.push_back(e);
        end
        @(negedge clk);
        v8  = 1'b0;
        v10 = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b0; v8 = 1'b0; v10 = 1'b0;
        qp = '0; chroma = 1'b0; cqo = '0; typ = 1'b0; inv = 1'b0; ts = '0;
        repeat (3) @(negedge clk);
        check("reset Q", longint'(q8), 0);
        check("reset offset", longint'(off8), 0);
        check("reset shift", longint'(sh8), 0);
        check("reset o_valid", longint'(ov8), 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready after reset", longint'(rdy8), 1);

        // BIT_DEPTH 8; consecutive sends hold i_valid through busy and land in the o_valid cycle.
        send(0, 32, 0,   0, 0, 0, 1, 20560,  2801664, 23,  7, 1);
        send(0, 32, 0,   0, 0, 1, 2,  1632,        4,  3,  7, 1);
        send(0, 40, 1,   0, 1, 0, 0, 26214,  5570560, 25,  8, 1);
        send(0, 51, 1,  12, 0, 0, 3, 18396,  5603328, 24, 10, 1);
        send(0,  0, 1, -12, 0, 1, 0,    40,        1,  1,  2, 1);
        repeat (3) @(negedge clk);
        send(0, 30, 1,   5, 1, 0, 2, 18396,   696320, 22,  7, 1);
        send(0, 63, 0,   0, 0, 1, 3, 14592,        8,  4, 10, 1);
        send(0, 20, 1, -16, 0, 1, 1,   102,        2,  2,  3, 1);
        send(0, 50, 1,   0, 0, 0, 1, 20560, 11206656, 25,  9, 1);

        // BIT_DEPTH 10
        send(1,  0, 0,   0, 0, 1, 0,   160,        4,  3,  4, 1);
        send(1,  0, 1, -12, 0, 0, 0, 26214,    43776, 17,  2, 1);
        send(1, 51, 0,   0, 1, 0, 3, 18396,  2785280, 24, 12, 1);

        guard = 0;
        while ((sb8.size() != 0 || sb10.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end

        // Abort a long job mid-DIV; its result must never appear.
        send(0, 51, 0, 0, 0, 0, 3, 0, 0, 0, 10, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid-job reset Q", longint'(q8), 0);
        check("mid-job reset offset", longint'(off8), 0);
        check("mid-job reset shift", longint'(sh8), 0);
        check("mid-job reset o_valid", longint'(ov8), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("ready after mid-job reset", longint'(rdy8), 1);
        check("output held zero after aborted job", longint'(q8), 0);

        send(0, 32, 0, 0, 0, 0, 1, 20560, 2801664, 23, 7, 1);
        guard = 0;
        while (sb8.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("dut8 scoreboard drained", longint'(sb8.size()), 0);
        check("dut10 scoreboard drained", longint'(sb10.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
